control_unit: RTL

Hardwired control sequencer for the Phase-1 CPU. It fetches each instruction through the datapath, decodes the IR, and for every cycle drives the one-hot register strobes, bus-source selects, ALU opcode and MUL/DIV qualifiers on the datapath's control inputs. It sits directly upstream of `datapath` and replaces the hand-written per-instruction state machines used in bench bring-up. Scope is fetch plus register-format ALU, unary, MUL/DIV, NOP and HALT.

---
 rtl/cu_pkg.sv | 71 +++++++
 rtl/cu_decoder.sv | 64 ++++++
 rtl/control_unit.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared definitions for the Phase-1 CPU control sequencer.
//
// Holds the opcode and ALU function encodings, the sequencer state enum,
// the instruction-class enum produced by the decoder, and a helper that turns
// a 4-bit register index into a 16-bit one-hot strobe.
//
// Optional feature macro: CU_MULDIV_EN (consumed by cu_decoder/control_unit).
package cu_pkg;

    // Instruction opcodes, IR[31:27]
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // ALU function codes driven on ALUop
    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_AND  = 4'd2;
    localparam logic [3:0] ALUOP_OR   = 4'd3;
    localparam logic [3:0] ALUOP_SHL  = 4'd4;
    localparam logic [3:0] ALUOP_SHR  = 4'd5;
    localparam logic [3:0] ALUOP_SHRA = 4'd6;
    localparam logic [3:0] ALUOP_ROL  = 4'd7;
    localparam logic [3:0] ALUOP_ROR  = 4'd8;
    localparam logic [3:0] ALUOP_NEG  = 4'd9;
    localparam logic [3:0] ALUOP_NOT  = 4'd10;

    // Sequencer states. T1 is split in two so that PCin can be a pure
    // function of state: S_T1 is the first memory-read cycle, S_T1W covers
    // every further cycle spent waiting on mem_rdy.
    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T1W,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } cuState_e;

    // Instruction classes; each class selects one path through T3..T6
    typedef enum logic [2:0] {
        CL_BIN,
        CL_UNARY,
        CL_MULDIV,
        CL_NOP,
        CL_HALT,
        CL_ILLEGAL
    } instrClass_e;

    // Register index to one-hot strobe
    function automatic logic [15:0] regOneHot(input logic [3:0] idx);
        regOneHot = 16'h0001 << idx;
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// cu_decoder: combinational instruction decoder for control_unit.
//
// Ports:
//   ir_i        in  32  instruction register contents
//   class_o     out     instruction class (BIN/UNARY/MULDIV/NOP/HALT/ILLEGAL)
//   aluOp_o     out  4  ALU function for BIN/UNARY classes (ADD otherwise)
//   isDiv_o     out  1  distinguishes div from mul inside the MULDIV class
//   raOneHot_o  out 16  one-hot of Ra, IR[26:23]
//   rbOneHot_o  out 16  one-hot of Rb, IR[22:19]
//   rcOneHot_o  out 16  one-hot of Rc, IR[18:15]
//
// Macro CU_MULDIV_EN: when undefined, mul and div decode as ILLEGAL.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [31:0]  ir_i,
    output instrClass_e  class_o,
    output logic [3:0]   aluOp_o,
    output logic         isDiv_o,
    output logic [15:0]  raOneHot_o,
    output logic [15:0]  rbOneHot_o,
    output logic [15:0]  rcOneHot_o
);

    logic [4:0] opcode;
    logic       unusedLowBits;

    assign opcode        = ir_i[31:27];
    // The register-format instructions handled here carry no immediate,
    // so the low IR bits are intentionally ignored.
    assign unusedLowBits = ^ir_i[14:0];

    assign raOneHot_o = regOneHot(ir_i[26:23]);
    assign rbOneHot_o = regOneHot(ir_i[22:19]);
    assign rcOneHot_o = regOneHot(ir_i[18:15]);

    // Opcode to class and ALU function; anything not listed is illegal
    always_comb begin
        class_o = CL_ILLEGAL;
        aluOp_o = ALUOP_ADD;
        isDiv_o = 1'b0;
        case (opcode)
            OP_ADD:  begin class_o = CL_BIN;   aluOp_o = ALUOP_ADD;  end
            OP_SUB:  begin class_o = CL_BIN;   aluOp_o = ALUOP_SUB;  end
            OP_AND:  begin class_o = CL_BIN;   aluOp_o = ALUOP_AND;  end
            OP_OR:   begin class_o = CL_BIN;   aluOp_o = ALUOP_OR;   end
            OP_ROR:  begin class_o = CL_BIN;   aluOp_o = ALUOP_ROR;  end
            OP_ROL:  begin class_o = CL_BIN;   aluOp_o = ALUOP_ROL;  end
            OP_SHR:  begin class_o = CL_BIN;   aluOp_o = ALUOP_SHR;  end
            OP_SHRA: begin class_o = CL_BIN;   aluOp_o = ALUOP_SHRA; end
            OP_SHL:  begin class_o = CL_BIN;   aluOp_o = ALUOP_SHL;  end
            OP_NEG:  begin class_o = CL_UNARY; aluOp_o = ALUOP_NEG;  end
            OP_NOT:  begin class_o = CL_UNARY; aluOp_o = ALUOP_NOT;  end
            OP_NOP:  class_o = CL_NOP;
            OP_HALT: class_o = CL_HALT;
`ifdef CU_MULDIV_EN
            OP_MUL:  class_o = CL_MULDIV;
            OP_DIV:  begin class_o = CL_MULDIV; isDiv_o = 1'b1; end
`endif
            default: class_o = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired control sequencer for the Phase-1 CPU datapath.
//
// Fetches through the datapath (T0..T2), then executes register-format ALU,
// unary, MUL/DIV, NOP and HALT instructions (T3..T6). All control outputs are
// a Moore function of the current state and the decoded IR fields.
//
// Parameter:
//   RETIRE_W   width of the retired-instruction counter (default 16)
// Ports:
//   clock                    in   rising-edge clock
//   clear                    in   synchronous active-low reset
//   run                      in   permits starting a new fetch
//   IR[31:0]                 in   datapath IR register contents
//   mem_rdy                  in   memory read-data valid
//   Rin[15:0], Rout[15:0]    out  one-hot register load / drive strobes
//   PCin PCout MARin MDRin MDRout IRin Yin IncPC Read           out
//   Zlowin Zhighin Zlowout Zhighout HIin LOin                   out
//   ALUop[3:0]               out  ALU function
//   ALU_MUL, ALU_DIV         out  64-bit op qualifiers
//   illegal                  out  one-cycle pulse on an undecodable opcode
//   halted                   out  high while in HALT
//   retired[RETIRE_W-1:0]    out  count of completed instructions (wraps)
//
// Macro CU_MULDIV_EN: enables mul/div decode and the T6 state. When it is
// undefined, ALU_MUL, ALU_DIV, Zhighin, Zhighout, HIin and LOin are tied low.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [31:0]         IR,
    input  logic                mem_rdy,
    output logic [15:0]         Rin,
    output logic [15:0]         Rout,
    output logic                PCin,
    output logic                PCout,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                IncPC,
    output logic                Read,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic [3:0]          ALUop,
    output logic                ALU_MUL,
    output logic                ALU_DIV,
    output logic                illegal,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired
);

    cuState_e            state_q;
    cuState_e            state_d;
    logic [RETIRE_W-1:0] retired_q;
    logic [RETIRE_W-1:0] retired_d;

    instrClass_e         instrClass;
    logic [3:0]          aluOp;
    logic                isDiv;
    logic [15:0]         raOneHot;
    logic [15:0]         rbOneHot;
    logic [15:0]         rcOneHot;

    logic                retireNow;
    cuState_e            afterLast;

    cu_decoder uDecoder (
        .ir_i       (IR),
        .class_o    (instrClass),
        .aluOp_o    (aluOp),
        .isDiv_o    (isDiv),
        .raOneHot_o (raOneHot),
        .rbOneHot_o (rbOneHot),
        .rcOneHot_o (rcOneHot)
    );

    // Where the last state of any instruction goes: straight into the next
    // fetch if run is still high, otherwise park in IDLE.
    assign afterLast = run ? S_T0 : S_IDLE;

    assign retired   = retired_q;
    assign retired_d = retireNow ? retired_q + RETIRE_W'(1) : retired_q;

    // State register and retire counter; clear wins from any state, HALT included
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q   <= S_IDLE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d   = state_q;
        retireNow = 1'b0;
        Rin       = '0;
        Rout      = '0;
        PCin      = 1'b0;
        PCout     = 1'b0;
        MARin     = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        Zlowin    = 1'b0;
        Zlowout   = 1'b0;
        ALUop     = ALUOP_ADD;
        illegal   = 1'b0;
        halted    = 1'b0;
`ifdef CU_MULDIV_EN
        Zhighin   = 1'b0;
        Zhighout  = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        ALU_MUL   = 1'b0;
        ALU_DIV   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_T0;
                end
            end
            S_T0: begin
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                Zlowin  = 1'b1;
                state_d = S_T1;
            end
            // First read cycle: the only one that loads the incremented PC
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = mem_rdy ? S_T2 : S_T1W;
            end
            S_T1W: begin
                Zlowout = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                state_d = mem_rdy ? S_T2 : S_T1W;
            end
            // NOP and illegal opcodes finish here; HALT locks up until clear
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                case (instrClass)
                    CL_HALT: state_d = S_HALT;
                    CL_NOP: begin
                        retireNow = 1'b1;
                        state_d   = afterLast;
                    end
                    CL_ILLEGAL: begin
                        illegal   = 1'b1;
                        retireNow = 1'b1;
                        state_d   = afterLast;
                    end
                    default: state_d = S_T3;
                endcase
            end
            // Unary ops compute directly from Rb and skip T4
            S_T3: begin
                case (instrClass)
                    CL_UNARY: begin
                        Rout    = rbOneHot;
                        ALUop   = aluOp;
                        Zlowin  = 1'b1;
                        state_d = S_T5;
                    end
`ifdef CU_MULDIV_EN
                    CL_MULDIV: begin
                        Rout    = raOneHot;
                        Yin     = 1'b1;
                        state_d = S_T4;
                    end
`endif
                    default: begin
                        Rout    = rbOneHot;
                        Yin     = 1'b1;
                        state_d = S_T4;
                    end
                endcase
            end
            S_T4: begin
                state_d = S_T5;
`ifdef CU_MULDIV_EN
                if (instrClass == CL_MULDIV) begin
                    Rout    = rbOneHot;
                    ALU_MUL = !isDiv;
                    ALU_DIV = isDiv;
                    Zlowin  = 1'b1;
                    Zhighin = 1'b1;
                end else
`endif
                begin
                    Rout   = rcOneHot;
                    ALUop  = aluOp;
                    Zlowin = 1'b1;
                end
            end
            // Low result goes to Ra, or to LO for mul/div which continue to T6
            S_T5: begin
                Zlowout = 1'b1;
`ifdef CU_MULDIV_EN
                if (instrClass == CL_MULDIV) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else
`endif
                begin
                    Rin       = raOneHot;
                    retireNow = 1'b1;
                    state_d   = afterLast;
                end
            end
            S_T6: begin
`ifdef CU_MULDIV_EN
                Zhighout = 1'b1;
                HIin     = 1'b1;
`endif
                retireNow = 1'b1;
                state_d   = afterLast;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifndef CU_MULDIV_EN
    // Without the mul/div feature the high-half and qualifier controls are dead
    logic unusedIsDiv;
    assign unusedIsDiv = isDiv;
    assign Zhighin     = 1'b0;
    assign Zhighout    = 1'b0;
    assign HIin        = 1'b0;
    assign LOin        = 1'b0;
    assign ALU_MUL     = 1'b0;
    assign ALU_DIV     = 1'b0;
`endif

endmodule
